// File: rtl/fir_stim_pkg.sv
// fir_stim_pkg: shared state encoding and control-word layout for the FIR stimulus driver.
package fir_stim_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_SEL_LSB = 1;
  localparam int CTRL_COEFF_LSB = 3;
  localparam int COEFF_W = 5;
  function automatic logic [7:0] ctrl_word(input logic [COEFF_W-1:0] c, input logic [1:0] s);
    return (8'(c) << CTRL_COEFF_LSB) | (8'(s) << CTRL_SEL_LSB) | (8'd1 << CTRL_EN_BIT);
  endfunction
endpackage

// File: rtl/fir_stim_fifo.sv
// fir_stim_fifo: sample buffer; DEPTH=1 degenerates to a single holding register.
module fir_stim_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign dout = mem[rd];
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      rd <= pop ? nxt(rd) : rd;
      wr <= push ? nxt(wr) : wr;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
endmodule

// File: rtl/fir_stim_driver.sv
// fir_stim_driver: loads FIR coefficients, flushes the delay line, then streams samples.
// FIR_STIM_FIFO_EN selects a 4-entry sample FIFO instead of a single holding register.
module fir_stim_driver #(
  parameter int NUM_COEFF = 4,
  parameter int SIZE = 8,
  parameter int COEFF_W = fir_stim_pkg::COEFF_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  input  logic [NUM_COEFF*COEFF_W-1:0] cfg_coeffs,
  output logic                         cfg_ready,
  input  logic                         s_valid,
  input  logic [SIZE-1:0]              s_data,
  output logic                         s_ready,
  output logic [7:0]                   fir_ctrl,
  output logic [SIZE-1:0]              fir_sample,
  output logic                         fir_shift_en,
  output logic                         busy
);
  import fir_stim_pkg::*;
`ifdef FIR_STIM_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  if (NUM_COEFF < 1 || NUM_COEFF > 4) begin : g_bad_num
    $error("NUM_COEFF must be in 1..4");
  end
  if (COEFF_W != fir_stim_pkg::COEFF_W) begin : g_bad_w
    $error("COEFF_W is fixed by the control-word layout");
  end
  state_t state;
  logic [1:0] idx, nidx;
  logic [NUM_COEFF*COEFF_W-1:0] coeffs;
  logic [SIZE-1:0] head;
  logic idle, empty, full, pop, push, bypass, last;
  assign idle = state == IDLE;
  assign pop = idle && !empty;
  assign cfg_ready = idle && empty;
  assign s_ready = !full || pop;
  assign busy = !idle || !empty;
  // an empty idle buffer forwards the sample directly so latency stays one cycle
  assign bypass = idle && empty && s_valid && !cfg_valid;
  assign push = s_valid && s_ready && !bypass;
  assign last = idx == 2'(NUM_COEFF - 1);
  assign nidx = idx + 2'd1;
  fir_stim_fifo #(.W(SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .din(s_data), .pop(pop),
    .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      coeffs <= '0;
      fir_ctrl <= '0;
      fir_sample <= '0;
      fir_shift_en <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (cfg_valid && cfg_ready) begin
            coeffs <= cfg_coeffs;
            idx <= '0;
            fir_ctrl <= ctrl_word(cfg_coeffs[COEFF_W-1:0], 2'd0);
            fir_shift_en <= 1'b0;
            state <= LOAD;
          end else begin
            fir_ctrl <= '0;
            fir_shift_en <= pop || bypass;
            fir_sample <= pop ? head : bypass ? s_data : fir_sample;
          end
        LOAD:
          if (last) begin
            idx <= '0;
            fir_ctrl <= '0;
            fir_sample <= '0;
            fir_shift_en <= 1'b1;
            state <= FLUSH;
          end else begin
            idx <= nidx;
            fir_ctrl <= ctrl_word(coeffs[int'(nidx)*COEFF_W +: COEFF_W], nidx);
          end
        FLUSH:
          if (last) begin
            idx <= '0;
            fir_shift_en <= 1'b0;
            state <= IDLE;
          end else idx <= nidx;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fir_stim_driver.sv
// tb_fir_stim_driver: directed table, corner sequences and random traffic against a queue-based model.
module tb_fir_stim_driver;
  localparam int NC = 4;
`ifdef FIR_STIM_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk, rst_n, cfg_valid, cfg_ready, s_valid, s_ready, fir_shift_en, busy;
  logic [NC*5-1:0] cfg_coeffs;
  logic [7:0] s_data, fir_ctrl, fir_sample;
  fir_stim_driver dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_coeffs(cfg_coeffs),
    .cfg_ready(cfg_ready), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fir_ctrl(fir_ctrl), .fir_sample(fir_sample), .fir_shift_en(fir_shift_en), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {logic [7:0] ctrl; logic en; logic [7:0] smp; logic hold;} out_t;
  typedef struct {
    logic cv; logic [NC*5-1:0] cc; logic sv; logic [7:0] sd;
    logic [7:0] ctrl; logic en; logic [7:0] smp; logic bsy;
  } vec_t;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_q[$];
  out_t m_sched[$];
  logic m_in_seq = 1'b0, e_en = 1'b0;
  logic [7:0] e_ctrl = '0, e_smp = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_q.delete();
    m_sched.delete();
    m_in_seq = 1'b0;
    e_ctrl = '0;
    e_en = 1'b0;
    e_smp = '0;
  endtask
  // One clock: check handshake/busy decode, advance the model, check registered outputs.
  task automatic step();
    logic idle, e_cr, e_sr, e_b;
    logic [NC*5-1:0] cc;
    out_t r;
    idle = !m_in_seq;
    e_cr = idle && m_q.size() == 0;
    e_sr = m_q.size() < DEPTH || (idle && m_q.size() > 0);
    e_b = !idle || m_q.size() > 0;
    chk("cfg_ready", cfg_ready, e_cr);
    chk("s_ready", s_ready, e_sr);
    chk("busy", busy, e_b);
    cc = cfg_coeffs;
    if (s_valid && e_sr) m_q.push_back(s_data);
    if (cfg_valid && e_cr) begin
      for (int k = 0; k < NC; k++) m_sched.push_back('{{cc[k*5 +: 5], 2'(k), 1'b1}, 1'b0, 8'h0, 1'b1});
      for (int k = 0; k < NC; k++) m_sched.push_back('{8'h0, 1'b1, 8'h0, 1'b0});
    end
    if (m_sched.size() > 0) begin
      r = m_sched.pop_front();
      m_in_seq = 1'b1;
      e_ctrl = r.ctrl;
      e_en = r.en;
      if (!r.hold) e_smp = r.smp;
    end else begin
      m_in_seq = 1'b0;
      e_ctrl = '0;
      e_en = 1'b0;
      if (idle && m_q.size() > 0) begin
        e_smp = m_q.pop_front();
        e_en = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("fir_ctrl", fir_ctrl, e_ctrl);
    chk("fir_shift_en", fir_shift_en, e_en);
    chk("fir_sample", fir_sample, e_smp);
  endtask
  localparam logic [NC*5-1:0] CC = {5'd2, 5'd7, 5'd1, 5'd3};
  localparam logic [NC*5-1:0] CC2 = {5'd31, 5'd16, 5'd8, 5'd4};
  vec_t tbl[13];
  int acc;
  initial begin
    tbl[0] = '{1'b1, CC, 1'b0, 8'h00, 8'h19, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{1'b0, CC, 1'b0, 8'h00, 8'h0B, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{1'b0, CC, 1'b0, 8'h00, 8'h3D, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{1'b0, CC, 1'b0, 8'h00, 8'h17, 1'b0, 8'h00, 1'b1};
    for (int i = 4; i < 8; i++) tbl[i] = '{1'b0, CC, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[8] = '{1'b0, CC, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[9] = '{1'b0, CC, 1'b1, 8'h10, 8'h00, 1'b1, 8'h10, 1'b0};
    tbl[10] = '{1'b0, CC, 1'b1, 8'h20, 8'h00, 1'b1, 8'h20, 1'b0};
    tbl[11] = '{1'b0, CC, 1'b1, 8'h30, 8'h00, 1'b1, 8'h30, 1'b0};
    tbl[12] = '{1'b0, CC, 1'b0, 8'h00, 8'h00, 1'b0, 8'h30, 1'b0};
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_coeffs = CC;
    s_valid = 1'b0;
    s_data = '0;
    #12;
    chk("rst_ctrl", fir_ctrl, 8'h00);
    chk("rst_en", fir_shift_en, 1'b0);
    chk("rst_sample", fir_sample, 8'h00);
    rst_n = 1'b1;
    #4;
    chk("rel_cfg_ready", cfg_ready, 1'b1);
    chk("rel_s_ready", s_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    chk("t1_k2_ctrl", fir_ctrl, 8'h3D);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_ctrl", fir_ctrl, 8'h00);
    chk("t1_rst_en", fir_shift_en, 1'b0);
    model_reset();
    #10;
    rst_n = 1'b1;
    #1;
    chk("t1_cfg_ready", cfg_ready, 1'b1);
    chk("t1_s_ready", s_ready, 1'b1);
    chk("t1_busy", busy, 1'b0);
    for (int i = 0; i < 13; i++) begin
      cfg_valid = tbl[i].cv;
      cfg_coeffs = tbl[i].cc;
      s_valid = tbl[i].sv;
      s_data = tbl[i].sd;
      step();
      chk($sformatf("tbl%0d_ctrl", i), fir_ctrl, tbl[i].ctrl);
      chk($sformatf("tbl%0d_en", i), fir_shift_en, tbl[i].en);
      chk($sformatf("tbl%0d_sample", i), fir_sample, tbl[i].smp);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
    end
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h55;
    step();
    s_valid = 1'b0;
    repeat (7) step();
    cfg_valid = 1'b1;
    cfg_coeffs = CC2;
    #1;
    chk("t4_blocked", cfg_ready, 1'b0);
    step();
    chk("t4_pop_en", fir_shift_en, 1'b1);
    chk("t4_pop_sample", fir_sample, 8'h55);
    chk("t4_cfg_ready", cfg_ready, 1'b1);
    step();
    chk("t4_load_k0", fir_ctrl, 8'h21);
    cfg_valid = 1'b0;
    repeat (8) step();
    cfg_valid = 1'b1;
    cfg_coeffs = CC;
    step();
    cfg_valid = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hA1;
    acc = 0;
    for (int i = 0; i < 2 * NC; i++) begin
      if (s_ready) acc++;
      step();
      if (acc > 0) s_data = 8'hA1 + 8'(acc);
    end
    chk("t5_accepted", 32'(acc), 32'(DEPTH));
    s_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk($sformatf("t5_out%0d_en", i), fir_shift_en, 1'b1);
      chk($sformatf("t5_out%0d_sample", i), fir_sample, 8'hA1 + 8'(i));
    end
    step();
    for (int i = 0; i < 3000; i++) begin
      cfg_valid = $urandom_range(15) == 0;
      cfg_coeffs = NC*5'($urandom);
      s_valid = $urandom_range(2) != 0;
      s_data = 8'($urandom);
      step();
    end
    cfg_valid = 1'b0;
    s_valid = 1'b0;
    repeat (20) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
